// File: rtl/vga_pixel_fetch.sv
// Framebuffer prefetch: fetches 16-bit words into a 4-word FIFO, emits one RRRGGGBB per pixel tick.
// Optional feature macro VGA_UNDERRUN_DET_EN: empty-FIFO pixels show magenta, sticky underrun flag.
module vga_pixel_fetch #(
   parameter int unsigned H_ACTIVE      = 640,
   parameter int unsigned V_ACTIVE      = 480,
   parameter int unsigned V_TOTAL       = 525,
   parameter int unsigned WORDS_PER_ROW = 80
) (
   input  logic        ext_clk,
   input  logic        reset,
   input  logic        pix_tick,
   input  logic [9:0]  hcount,
   input  logic [9:0]  vcount,
   input  logic        on,
   output logic        mem_req,
   output logic [13:0] mem_addr,
   input  logic        mem_gnt,
   input  logic [15:0] mem_rdata,
   output logic [7:0]  color,
   output logic        underrun
);

   localparam int unsigned Depth = 4;

   typedef enum logic [1:0] {StIdle, StReq, StData} fetch_state_e;

   fetch_state_e state_q;
   logic [15:0]  fifo_mem_q [Depth];
   logic [1:0]   rd_ptr_q;
   logic [1:0]   wr_ptr_q;
   logic [2:0]   count_q;
   logic [6:0]   words_left_q;
   logic [13:0]  fetch_ptr_q;
   logic         mem_req_q;
   logic [13:0]  mem_addr_q;
   logic [7:0]   color_q;

   logic [10:0]  v_inc;
   logic [10:0]  nv;
   logic [13:0]  row;
   logic [13:0]  row_base;
   logic         line_start;
   logic         fifo_empty;
   logic         push;
   logic         pop;
   logic [2:0]   fill_after;
   logic         fetch_ok;
   logic [15:0]  head;
   logic [7:0]   pixel_byte;

   always_comb begin
      v_inc      = {1'b0, vcount} + 11'd1;
      nv         = (v_inc >= 11'(V_TOTAL)) ? (v_inc - 11'(V_TOTAL)) : v_inc;
      line_start = pix_tick && (hcount == 10'(H_ACTIVE)) && (nv < 11'(V_ACTIVE));
      // Row times 80 as shift-and-add.
      row        = {5'd0, nv[10:2]};
      row_base   = (row << 6) + (row << 4);
      fifo_empty = (count_q == 3'd0);
      head       = fifo_mem_q[rd_ptr_q];
      pixel_byte = hcount[2] ? head[7:0] : head[15:8];
      pop        = pix_tick && on && (hcount[2:0] == 3'b111) && !fifo_empty;
      push       = (state_q == StData);
      // Stored plus in-flight words once this cycle's push/pop settle.
      fill_after = count_q + {2'b00, push} - {2'b00, pop};
      fetch_ok   = (words_left_q != 7'd0) && (fill_after < 3'(Depth));
   end

   always_ff @(posedge ext_clk) begin
      if (reset) begin
         state_q      <= StIdle;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= 14'd0;
         words_left_q <= 7'd0;
         fetch_ptr_q  <= 14'd0;
      end else if (line_start) begin
         state_q      <= StIdle;
         mem_req_q    <= 1'b0;
         words_left_q <= 7'(WORDS_PER_ROW);
         fetch_ptr_q  <= row_base;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (fetch_ok) begin
                  state_q    <= StReq;
                  mem_req_q  <= 1'b1;
                  mem_addr_q <= fetch_ptr_q;
               end
            end
            StReq: begin
               if (mem_gnt) begin
                  state_q      <= StData;
                  mem_req_q    <= 1'b0;
                  fetch_ptr_q  <= fetch_ptr_q + 14'd1;
                  words_left_q <= words_left_q - 7'd1;
               end
            end
            StData: begin
               if (fetch_ok) begin
                  state_q    <= StReq;
                  mem_req_q  <= 1'b1;
                  mem_addr_q <= fetch_ptr_q;
               end else begin
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q   <= StIdle;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   // Flushing on line start also drops a word landing in the same cycle.
   always_ff @(posedge ext_clk) begin
      if (reset || line_start) begin
         rd_ptr_q <= 2'd0;
         wr_ptr_q <= 2'd0;
         count_q  <= 3'd0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 2'd1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 2'd1;
         end
         count_q <= fill_after;
      end
   end

   always_ff @(posedge ext_clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= mem_rdata;
      end
   end

`ifdef VGA_UNDERRUN_DET_EN
   logic underrun_q;

   always_ff @(posedge ext_clk) begin
      if (reset) begin
         color_q    <= 8'h00;
         underrun_q <= 1'b0;
      end else if (pix_tick) begin
         if (!on) begin
            color_q <= 8'h00;
         end else if (!fifo_empty) begin
            color_q <= pixel_byte;
         end else begin
            color_q    <= 8'hE3;
            underrun_q <= 1'b1;
         end
      end
   end

   assign underrun = underrun_q;
`else
   always_ff @(posedge ext_clk) begin
      if (reset) begin
         color_q <= 8'h00;
      end else if (pix_tick) begin
         if (on && !fifo_empty) begin
            color_q <= pixel_byte;
         end else begin
            color_q <= 8'h00;
         end
      end
   end

   assign underrun = 1'b0;
`endif

   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;
   assign color    = color_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch: expected colors queued at each pixel tick, compared next cycle.
module tb_vga_pixel_fetch;

`ifdef VGA_UNDERRUN_DET_EN
   localparam logic [7:0] EMPTY_COLOR = 8'hE3;
   localparam logic       EXP_UR      = 1'b1;
`else
   localparam logic [7:0] EMPTY_COLOR = 8'h00;
   localparam logic       EXP_UR      = 1'b0;
`endif

   logic        ext_clk = 1'b0;
   logic        reset = 1'b1;
   logic        pix_tick = 1'b0;
   logic [9:0]  hcount = 10'd0;
   logic [9:0]  vcount = 10'd0;
   logic        on = 1'b0;
   logic        mem_req;
   logic [13:0] mem_addr;
   logic        mem_gnt = 1'b1;
   logic [15:0] mem_rdata = 16'hDEAD;
   logic [7:0]  color;
   logic        underrun;

   int n_cmp = 0;
   int n_mis = 0;

   logic [7:0]  exp_q[$];
   logic [13:0] gaddr_q[$];
   int          gnt_cnt = 0;
   int          occ = 0;
   int          max_occ = 0;
   int          viol = 0;
   logic        pend = 1'b0;
   logic [13:0] pend_addr = 14'd0;

   vga_pixel_fetch dut (
      .ext_clk  (ext_clk),
      .reset    (reset),
      .pix_tick (pix_tick),
      .hcount   (hcount),
      .vcount   (vcount),
      .on       (on),
      .mem_req  (mem_req),
      .mem_addr (mem_addr),
      .mem_gnt  (mem_gnt),
      .mem_rdata(mem_rdata),
      .color    (color),
      .underrun (underrun)
   );

   always #5 ext_clk = ~ext_clk;

   // Memory returns {addr[7:0], ~addr[7:0]} one cycle after each grant.
   always @(posedge ext_clk) begin
      if (mem_req && mem_gnt) begin
         mem_rdata <= {mem_addr[7:0], ~mem_addr[7:0]};
      end else begin
         mem_rdata <= 16'hDEAD;
      end
   end

   // Grant log, occupancy model (granted minus popped) and request-hold monitor.
   always @(posedge ext_clk) begin
      automatic int  nv_m  = (int'(vcount) + 1) % 525;
      automatic bit  ls_ev = pix_tick && (hcount == 10'd640) && (nv_m < 480);
      automatic bit  grant = mem_req && mem_gnt;
      automatic bit  pop_m = pix_tick && on && (hcount[2:0] == 3'b111) && (occ > 0);
      automatic int  nxt   = occ + (grant ? 1 : 0) - (pop_m ? 1 : 0);
      if (grant) begin
         gnt_cnt <= gnt_cnt + 1;
         gaddr_q.push_back(mem_addr);
      end
      if (reset || ls_ev) begin
         occ <= 0;
      end else begin
         occ <= nxt;
         if (grant && nxt > max_occ) max_occ <= nxt;
      end
      if (pend && (!mem_req || mem_addr !== pend_addr)) viol <= viol + 1;
      pend      <= mem_req && !mem_gnt && !reset && !ls_ev;
      pend_addr <= mem_addr;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_color(input int h, input int v);
      logic [7:0] a;
      a = 8'((v / 4) * 80 + h / 8);
      return ((h % 8) >= 4) ? ~a : a;
   endfunction

   function automatic int prev_line(input int v);
      return (v == 0) ? 524 : v - 1;
   endfunction

   // One pixel slot of 4 clocks; a checked tick queues its expected color and compares it next cycle.
   task automatic do_tick(input int h, input int v, input bit o, input bit chk,
                          input logic [7:0] exp);
      logic [7:0] e;
      @(negedge ext_clk);
      pix_tick = 1'b1;
      hcount   = 10'(h);
      vcount   = 10'(v);
      on       = o;
      if (chk) exp_q.push_back(exp);
      @(negedge ext_clk);
      pix_tick = 1'b0;
      if (chk) begin
         if (exp_q.size() == 0) begin
            check($sformatf("scoreboard_empty h=%0d v=%0d", h, v), 32'd0, 32'd1);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("color h=%0d v=%0d", h, v), {24'd0, color}, {24'd0, e});
         end
      end
      repeat (2) @(negedge ext_clk);
   endtask

   task automatic line_start_blank(input int v);
      gaddr_q.delete();
      for (int h = 640; h < 648; h++) do_tick(h, prev_line(v), 1'b0, 1'b0, 8'h00);
   endtask

   task automatic run_line(input int v, input logic [13:0] base);
      int g0;
      g0 = gnt_cnt;
      line_start_blank(v);
      check($sformatf("first_addr v=%0d", v),
            (gaddr_q.size() > 0) ? {18'd0, gaddr_q[0]} : 32'hFFFF_FFFF, {18'd0, base});
      for (int h = 0; h < 640; h++) do_tick(h, v, 1'b1, 1'b1, exp_color(h, v));
      check($sformatf("grants v=%0d", v), gnt_cnt - g0, 32'd80);
   endtask

   initial begin
      int  g0;
      bit  found;

      // Reset held 3 cycles with grant high.
      mem_gnt = 1'b1;
      reset   = 1'b1;
      repeat (3) @(posedge ext_clk);
      @(negedge ext_clk);
      check("rst_color", {24'd0, color}, 32'h00);
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_mem_addr", {18'd0, mem_addr}, 32'd0);
      check("rst_underrun", {31'd0, underrun}, 32'd0);
      reset = 1'b0;
      repeat (4) @(negedge ext_clk);
      check("idle_no_req", {31'd0, mem_req}, 32'd0);

      // Frame start: line 524 -> line 0, first four addresses before hcount 0.
      g0 = gnt_cnt;
      line_start_blank(0);
      check("prefill_count", (gaddr_q.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("prefill_addr%0d", i),
               (gaddr_q.size() > i) ? {18'd0, gaddr_q[i]} : 32'hFFFF_FFFF, i);
      end
      for (int h = 0; h < 640; h++) do_tick(h, 0, 1'b1, 1'b1, exp_color(h, 0));
      check("grants v=0", gnt_cnt - g0, 32'd80);

      // Row repeat and row advance.
      run_line(1, 14'h000);
      run_line(2, 14'h000);
      run_line(3, 14'h000);
      run_line(4, 14'h050);
      run_line(479, 14'h2530);
      check("underrun_clean", {31'd0, underrun}, 32'd0);

      // Out-of-window lines never fetch.
      g0 = gnt_cnt;
      for (int h = 640; h < 660; h++) do_tick(h, 479, 1'b0, 1'b0, 8'h00);
      for (int h = 640; h < 660; h++) do_tick(h, 523, 1'b0, 1'b0, 8'h00);
      check("no_fetch_vblank", gnt_cnt - g0, 32'd0);

      // Grant stall from line start through hcount 40 of line 0.
      @(negedge ext_clk);
      mem_gnt = 1'b0;
      line_start_blank(0);
      check("stall_req_held", {31'd0, mem_req}, 32'd1);
      check("stall_addr", {18'd0, mem_addr}, 32'd0);
      for (int h = 0; h <= 40; h++) do_tick(h, 0, 1'b1, 1'b1, EMPTY_COLOR);
      mem_gnt = 1'b1;
      for (int h = 41; h < 640; h++) do_tick(h, 0, 1'b1, 1'b0, 8'h00);
      check("stall_underrun", {31'd0, underrun}, {31'd0, EXP_UR});
      run_line(1, 14'h000);
      check("underrun_sticky", {31'd0, underrun}, {31'd0, EXP_UR});

      // Reset in DATA state: request drops, FIFO empty, stale word never shown.
      gaddr_q.delete();
      @(negedge ext_clk);
      pix_tick = 1'b1;
      hcount   = 10'd640;
      vcount   = 10'd1;
      on       = 1'b0;
      @(negedge ext_clk);
      pix_tick = 1'b0;
      found    = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (mem_req && mem_gnt) found = 1'b1;
         else @(negedge ext_clk);
      end
      check("grant_seen", {31'd0, found}, 32'd1);
      @(negedge ext_clk);
      reset = 1'b1;
      @(negedge ext_clk);
      reset = 1'b0;
      check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
      check("midrst_mem_addr", {18'd0, mem_addr}, 32'd0);
      check("midrst_underrun", {31'd0, underrun}, 32'd0);
      do_tick(4, 2, 1'b1, 1'b1, EMPTY_COLOR);
      repeat (8) @(negedge ext_clk);
      check("midrst_no_req", {31'd0, mem_req}, 32'd0);
      run_line(3, 14'h000);

      check("max_outstanding", max_occ, 32'd4);
      check("req_hold_violations", viol, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/vga_pixel_fetch.md
# vga_pixel_fetch

Framebuffer prefetch stage that sits directly upstream of the VGA sync/color output in `computer`. It reads 16-bit video-RAM words through the memory arbiter during horizontal blanking and the active line, buffers them in a 4-word FIFO, and delivers one 8-bit RRRGGGBB `color` per pixel tick in step with the timing generator's `hcount`/`vcount`. The framebuffer is 160x120 at 8 bpp, with two pixels per word, 4x pixel-doubled to 640x480.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `V_ACTIVE`, 480, visible lines
- `V_TOTAL`, 525, total lines per frame
- `WORDS_PER_ROW`, 80, framebuffer words per row (160 px / 2)
- `ext_clk` input 1: single system clock; all logic is on its rising edge.
- `reset` input 1: synchronous reset, active-high.
- `pix_tick` input 1: one-cycle pixel strobe from the timing generator, once every 4 `ext_clk`.
- `hcount` input 10: current pixel column; valid on `pix_tick`.
- `vcount` input 10: current line; valid on `pix_tick`.
- `on` input 1: visible-region flag from the timing generator.
- `mem_req` output 1: read request to the arbiter.
- `mem_addr` output 14: word address; held stable while `mem_req`=1.
- `mem_gnt` input 1: grant; a read completes on the cycle with `mem_req`&&`mem_gnt`.
- `mem_rdata` input 16: read data, valid exactly 1 cycle after grant.
- `color` output 8: registered pixel color.
- `underrun` output 1: sticky FIFO-underrun flag (see Configuration).

## Operation
- **Line start.** The event is `pix_tick` && `hcount`==`H_ACTIVE` && nv<`V_ACTIVE`, where nv=(`vcount`+1) mod `V_TOTAL`.
  - Flush the FIFO and set `row_base`=(nv>>2)*80.
  - Implement the multiply as (r<<6)+(r<<4), 14 bits; no multiplier.
  - Set `words_left`=80 and the fetch pointer to `row_base`.
  - Discard any data in flight.
- **Fetch FSM** (IDLE, REQ, DATA):
  - IDLE→REQ when `words_left`>0 and `fifo_count`<4. `fifo_count` counts stored words plus in-flight words.
  - REQ: assert `mem_req` with `mem_addr`=pointer. On `mem_gnt`, go to DATA, increment the pointer, and decrement `words_left`.
  - DATA: push `mem_rdata`, then go to REQ if the IDLE condition still holds, else IDLE.
  - A line start in any state returns the FSM to IDLE on the next cycle with the new row loaded, and drops `mem_req`.
- **Pixel mapping.**
  - fb_x = `hcount`>>2.
  - Even fb_x uses head word [15:8]; odd fb_x uses head word [7:0].
  - Pop the head when `pix_tick` && `on` && `hcount`[2:0]==3'b111.
- **Color output.**
  - On `pix_tick`: `color` = `on` ? selected byte : 8'h00.
  - If `on` and the FIFO is empty, underrun handling applies.
- **Simultaneous push and pop:** count unchanged; the FIFO never overflows because the in-flight word is counted.
- **Reset mid-operation:** `mem_req` drops on the next edge, the FIFO empties, and a pending `mem_rdata` is ignored.

## Timing
- **Reset values:** `color`=0, `mem_req`=0, `mem_addr`=0, `underrun`=0, FSM=IDLE, FIFO empty, `words_left`=0.
- **Read cost:** at best 2 `ext_clk` per word (REQ with grant, then DATA). Consumption is 1 word per 32 `ext_clk`, so a 4-deep FIFO fills within 8 cycles of line start.
- **Color latency:** `color` updates 1 `ext_clk` after the `pix_tick` whose `hcount`/`vcount` it belongs to. The sync stage delays HSync/VSync by 1 cycle to match.
- **Request hold:** `mem_req`/`mem_addr` stay constant until granted; `mem_req` never deasserts without a grant except on line start or reset.
- **Out-of-window lines:** no fetch occurs on lines where nv ≥ `V_ACTIVE`. `vcount`=`V_TOTAL`-1 wraps to nv=0, prefetching row 0.

## Configuration
- `VGA_UNDERRUN_DET_EN` defined:
  - A visible pixel with an empty FIFO outputs 8'hE3 (magenta).
  - `underrun` is set and stays set until `reset`.
- Undefined:
  - An empty FIFO outputs 8'h00.
  - `underrun` is tied to 0.

## Test plan
- **Reset:** hold `reset` 3 cycles with `mem_gnt`=1 → `color`=0x00, `mem_req`=0, `mem_addr`=0, `underrun`=0.
- **Frame start:** `mem_gnt`=1, memory returns {addr[7:0], ~addr[7:0]}; run line 524 → line 0.
  - Line 0: `hcount` 0-3 `color`=0x00, 4-7 0xFF, 8-11 0x01, 12-15 0xFE.
  - `mem_addr` sequence 0,1,2,3 before `hcount` 0.
- **Row repeat:** lines 1-3 refetch base 0x000; line 4 fetches from base 0x050 (80); line 479 fetches from base 119*80=0x2530.
- **Backpressure:** `mem_gnt`=1 continuously → at most 4 words outstanding; `mem_req` low once FIFO+in-flight=4; exactly 80 grants per visible line.
- **Grant stall:** `mem_gnt`=0 from line start through `hcount`=40 of line 0 → with `VGA_UNDERRUN_DET_EN`, `color`=0xE3 and `underrun`=1 sticky; without it, `color`=0x00 and `underrun`=0.
- **Reset mid-fetch:** assert `reset` in DATA state → next edge `mem_req`=0 and FIFO empty; the stale `mem_rdata` never appears on `color`.
